// File: rtl/adder_station.sv
// Reservation station plus integer adder functional unit (ADD/SUB/ADDI/SUBI).
// Holds one instruction. It resolves the source operands from the register
// file or by snooping the result bus. It then executes for EXEC_LAT cycles and
// drives its result for one cycle into the result-bus slice selected by its ROB tag.
module adder_station #(
  parameter int FU_ID     = 0,
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 4,
  parameter int REG_INDEX = 5,
  parameter int FU_INDEX  = 4,
  parameter int EXEC_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [FU_INDEX-1:0]          issue_fu,
  input  logic [WORD_SIZE-1:0]         issue_inst,
  input  logic [RB_INDEX-1:0]          issue_rb_index,
  output logic [REG_INDEX-1:0]         numj,
  output logic [REG_INDEX-1:0]         numk,
  input  logic [WORD_SIZE-1:0]         vj,
  input  logic [WORD_SIZE-1:0]         vk,
  input  logic [RB_INDEX-1:0]          qj,
  input  logic [RB_INDEX-1:0]          qk,
  input  logic [RB_SIZE*WORD_SIZE-1:0] snoop_data,
  input  logic [RB_SIZE-1:0]           snoop_valid,
  output logic                         busy,
  output logic [RB_SIZE*WORD_SIZE-1:0] res_data,
  output logic [RB_SIZE-1:0]           res_valid
);

  localparam logic [RB_INDEX-1:0] READY = '1;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, BCAST} state_t;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [RB_INDEX-1:0]   tag_q, tag_d;
  logic [WORD_SIZE-1:0]  vj_q, vj_d, vk_q, vk_d;
  logic [RB_INDEX-1:0]   qj_q, qj_d, qk_q, qk_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]  result_q, result_d;

  // Operand candidates for this cycle, before and after snooping.
  logic                  resolve;
  logic [WORD_SIZE-1:0]  jv_in, kv_in, jv, kv;
  logic [RB_INDEX-1:0]   jq_in, kq_in, jq, kq;
  logic                  is_imm;
  logic [WORD_SIZE-1:0]  alu_out;

  // The destination register field is not needed by the functional unit.
  logic unused_rd;
  assign unused_rd = ^issue_inst[27:23];

  // State and entry registers; reset puts the unit into an empty, ready-tagged state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      vj_q     <= '0;
      vk_q     <= '0;
      qj_q     <= READY;
      qk_q     <= READY;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Adder/subtractor. Opcodes other than the four supported ones produce zero.
  always_comb begin
    case (op_q)
      OP_ADD, OP_ADDI: alu_out = vj_q + vk_q;
      OP_SUB, OP_SUBI: alu_out = vj_q - vk_q;
      default:         alu_out = '0;
    endcase
  end

  // Next-state logic: accept issue, resolve operands by snooping, count execute cycles.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    resolve  = 1'b0;
    is_imm   = (issue_inst[31:28] == OP_ADDI) || (issue_inst[31:28] == OP_SUBI);
    jv_in    = vj_q;
    jq_in    = qj_q;
    kv_in    = vk_q;
    kq_in    = qk_q;

    case (state_q)
      IDLE: begin
        if (issue_fu == FU_INDEX'(FU_ID)) begin
          resolve = 1'b1;
          op_d    = issue_inst[31:28];
          tag_d   = issue_rb_index;
          jv_in   = vj;
          jq_in   = qj;
          if (is_imm) begin
            kv_in = {{(WORD_SIZE-13){issue_inst[12]}}, issue_inst[12:0]};
            kq_in = READY;
          end else begin
            kv_in = vk;
            kq_in = qk;
          end
        end
      end
      WAIT_OPS: resolve = 1'b1;
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_out;
          state_d  = BCAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pending tag is matched against the original tag value. This keeps a
    // capture from being re-matched once the tag reads READY.
    jv = jv_in;
    jq = jq_in;
    kv = kv_in;
    kq = kq_in;
    for (int i = 0; i < RB_SIZE; i++) begin
      if (jq_in != READY && jq_in == RB_INDEX'(i) && snoop_valid[i]) begin
        jv = snoop_data[i*WORD_SIZE +: WORD_SIZE];
        jq = READY;
      end
      if (kq_in != READY && kq_in == RB_INDEX'(i) && snoop_valid[i]) begin
        kv = snoop_data[i*WORD_SIZE +: WORD_SIZE];
        kq = READY;
      end
    end

    if (resolve) begin
      vj_d = jv;
      qj_d = jq;
      vk_d = kv;
      qk_d = kq;
      if (jq == READY && kq == READY) begin
        state_d = EXEC;
        cnt_d   = CW'(EXEC_LAT - 1);
      end else begin
        state_d = WAIT_OPS;
      end
    end

    // Flush wins over issue and snoop; the entry is simply abandoned.
    if (flush) state_d = IDLE;
  end

  // Status and register-file lookup outputs.
  always_comb begin
    busy = (state_q != IDLE);
    numj = REG_INDEX'(issue_inst[22:18]);
    numk = REG_INDEX'(issue_inst[17:13]);
  end

  // Result bus: only the slice owned by this entry's tag is driven during BCAST.
  generate
    for (genvar gi = 0; gi < RB_SIZE; gi++) begin : g_slot
      assign res_valid[gi] = (state_q == BCAST) && (tag_q == RB_INDEX'(gi));
      assign res_data[gi*WORD_SIZE +: WORD_SIZE] = res_valid[gi] ? result_q : '0;
    end
  endgenerate

endmodule
